// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet sprite scheduler.
package bullet_pkg;

  localparam int unsigned SPR_DIM = 8;
  localparam int unsigned COORD_W = 10;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    dir_t               dir;
    logic               active;
  } bullet_t;

  // Slot index width; a single-slot build still carries a 1-bit index.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bullet_render_sched_if.sv
// Table-write, pixel-scan, sprite-ROM and result signals of the bullet scheduler.
interface bullet_render_sched_if #(
  parameter int unsigned N_BULLETS = 4
);
  localparam int unsigned IdxW = bullet_pkg::idx_width(N_BULLETS);

  logic            frame_start;
  logic            wr_en;
  logic [IdxW-1:0] wr_idx;
  logic [9:0]      wr_x;
  logic [9:0]      wr_y;
  logic [1:0]      wr_dir;
  logic            wr_active;
  logic [9:0]      DrawX;
  logic [9:0]      DrawY;
  logic            blank;
  logic [5:0]      rom_addr;
  logic            rom_q;
  logic            bullet_on;
  logic [IdxW-1:0] bullet_idx;
  logic            overlap_frame;

  modport master (
    output frame_start, wr_en, wr_idx, wr_x, wr_y, wr_dir, wr_active,
    output DrawX, DrawY, blank, rom_q,
    input  rom_addr, bullet_on, bullet_idx, overlap_frame
  );

  modport slave (
    input  frame_start, wr_en, wr_idx, wr_x, wr_y, wr_dir, wr_active,
    input  DrawX, DrawY, blank, rom_q,
    output rom_addr, bullet_on, bullet_idx, overlap_frame
  );

endinterface

// File: rtl/bullet_addr_xform.sv
// Maps sprite-local coordinates to a ROM address, re-orienting the down-facing base sprite.
module bullet_addr_xform
  import bullet_pkg::*;
(
  input  logic [2:0] lx_i,
  input  logic [2:0] ly_i,
  input  dir_t       dir_i,
  output logic [5:0] addr_o
);

  // addr = row*8 + col; ~v is 7-v for 3-bit values.
  always_comb begin
    addr_o = {ly_i, lx_i};
    unique case (dir_i)
      DIR_DOWN:  addr_o = {ly_i, lx_i};
      DIR_UP:    addr_o = {~ly_i, lx_i};
      DIR_LEFT:  addr_o = {lx_i, ly_i};
      DIR_RIGHT: addr_o = {~lx_i, ly_i};
      default:   addr_o = {ly_i, lx_i};
    endcase
  end

endmodule

// File: rtl/bullet_render_sched.sv
// Per-pixel bullet sprite scheduler: shadow/live slot tables, priority hit test, 2-stage pipe.
// Optional overlap detector enabled by defining BULLET_OVERLAP_DETECT_EN.
module bullet_render_sched
  import bullet_pkg::*;
#(
  parameter int unsigned N_BULLETS = 4,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480
) (
  input logic                  vga_clk,
  input logic                  reset_n,
  bullet_render_sched_if.slave bus
);

  localparam int unsigned IdxW = idx_width(N_BULLETS);

  bullet_t [N_BULLETS-1:0] shadow_q, shadow_d;
  bullet_t [N_BULLETS-1:0] live_q, live_d;

  logic            hit1_q, hit1_d;
  logic [IdxW-1:0] idx1_q, idx1_d;
  logic [5:0]      rom_addr_q, rom_addr_d;
  logic            on_q, on_d;
  logic [IdxW-1:0] idx2_q, idx2_d;

  // Live loads the pre-write shadow, so a same-cycle write waits for the next frame.
  always_comb begin
    live_d   = bus.frame_start ? shadow_q : live_q;
    shadow_d = shadow_q;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (bus.wr_en && (bus.wr_idx == IdxW'(i))) begin
        shadow_d[i] = '{x:      bus.wr_x,
                        y:      bus.wr_y,
                        dir:    dir_t'(bus.wr_dir),
                        active: bus.wr_active};
      end
    end
  end

  logic                          draw_en;
  logic [10:0]                   dx, dy;
  logic [N_BULLETS-1:0]          hit_vec;
  logic [N_BULLETS-1:0][2:0]     lx_all, ly_all;

  // 11-bit unsigned differences: pixels left/above a sprite wrap to large values and miss.
  always_comb begin
    draw_en = bus.blank && (32'(bus.DrawX) < H_ACTIVE) && (32'(bus.DrawY) < V_ACTIVE);
    dx      = '0;
    dy      = '0;
    hit_vec = '0;
    lx_all  = '0;
    ly_all  = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      dx = {1'b0, bus.DrawX} - {1'b0, live_q[i].x};
      dy = {1'b0, bus.DrawY} - {1'b0, live_q[i].y};
      hit_vec[i] = draw_en && live_q[i].active &&
                   (dx < 11'(SPR_DIM)) && (dy < 11'(SPR_DIM));
      lx_all[i]  = dx[2:0];
      ly_all[i]  = dy[2:0];
    end
  end

  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [2:0]      win_lx, win_ly;
  dir_t            win_dir;
  logic [5:0]      xf_addr;

  // Descending scan so the lowest hitting slot is the last (winning) assignment.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_lx    = '0;
    win_ly    = '0;
    win_dir   = DIR_DOWN;
    for (int i = int'(N_BULLETS) - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(i);
        win_lx    = lx_all[i];
        win_ly    = ly_all[i];
        win_dir   = live_q[i].dir;
      end
    end
  end

  bullet_addr_xform u_addr_xform (
    .lx_i   (win_lx),
    .ly_i   (win_ly),
    .dir_i  (win_dir),
    .addr_o (xf_addr)
  );

  always_comb begin
    hit1_d     = win_found;
    idx1_d     = win_idx;
    rom_addr_d = win_found ? xf_addr : 6'd0;
    on_d       = hit1_q && bus.rom_q;
    idx2_d     = idx1_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= '0;
      live_q     <= '0;
      hit1_q     <= 1'b0;
      idx1_q     <= '0;
      rom_addr_q <= '0;
      on_q       <= 1'b0;
      idx2_q     <= '0;
    end else begin
      shadow_q   <= shadow_d;
      live_q     <= live_d;
      hit1_q     <= hit1_d;
      idx1_q     <= idx1_d;
      rom_addr_q <= rom_addr_d;
      on_q       <= on_d;
      idx2_q     <= idx2_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.bullet_on  = on_q;
  assign bus.bullet_idx = idx2_q;

`ifdef BULLET_OVERLAP_DETECT_EN
  logic multi_hit;
  logic flag_q, flag_d;
  logic overlap_q, overlap_d;

  // Two or more bits set in hit_vec; hit_vec is already gated by visible active video.
  assign multi_hit = |(hit_vec & (hit_vec - N_BULLETS'(1)));

  always_comb begin
    flag_d    = bus.frame_start ? 1'b0 : (flag_q | multi_hit);
    overlap_d = bus.frame_start ? flag_q : overlap_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q    <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      flag_q    <= flag_d;
      overlap_q <= overlap_d;
    end
  end

  assign bus.overlap_frame = overlap_q;
`else
  assign bus.overlap_frame = 1'b0;
`endif

endmodule

// File: tb/tb_bullet_render_sched.sv
// Self-checking bench for bullet_render_sched: directed table, corner sequences, random vs model.
module tb_bullet_render_sched;
  import bullet_pkg::*;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bullet_render_sched_if #(.N_BULLETS(NB)) bus ();

  logic [63:0] rom_bits;
  assign bus.rom_q = rom_bits[bus.rom_addr];

  bullet_render_sched #(
    .N_BULLETS (NB),
    .H_ACTIVE  (640),
    .V_ACTIVE  (480)
  ) dut (
    .vga_clk (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int x;
    int y;
    int dir;
    bit act;
  } slot_m_t;

  slot_m_t sh[NB];
  slot_m_t lv[NB];
  bit      m_flag, m_ovl;
  bit      p_hit;
  int      p_idx, p_addr;
  int      n_vec = 0;
  int      n_bad = 0;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      sh[i] = '{0, 0, 0, 1'b0};
      lv[i] = '{0, 0, 0, 1'b0};
    end
    m_flag = 1'b0;
    m_ovl  = 1'b0;
    p_hit  = 1'b0;
    p_idx  = 0;
    p_addr = 0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: first active slot (lowest index) whose 8x8 box contains the pixel.
  task automatic eval(input int px, input int py, input bit bl,
                      output bit hit, output int idx, output int addr, output int nhit);
    int lx, ly, row, col;
    hit = 1'b0; idx = 0; addr = 0; nhit = 0;
    for (int i = 0; i < NB; i++) begin
      lx = px - lv[i].x;
      ly = py - lv[i].y;
      if (bl && px < 640 && py < 480 && lv[i].act &&
          lx >= 0 && lx < 8 && ly >= 0 && ly < 8) begin
        nhit++;
        case (lv[i].dir)
          0:       begin row = 7 - ly; col = lx; end
          1:       begin row = ly;     col = lx; end
          2:       begin row = lx;     col = ly; end
          default: begin row = 7 - lx; col = ly; end
        endcase
        if (!hit) begin
          hit  = 1'b1;
          idx  = i;
          addr = row * 8 + col;
        end
      end
    end
  endtask

  task automatic tick(input bit fs, input bit we, input int wi, input int wx, input int wy,
                      input int wd, input bit wa, input int px, input int py, input bit bl);
    bit h;
    int id, ad, nh;
    bus.frame_start = fs;
    bus.wr_en       = we;
    bus.wr_idx      = 2'(wi);
    bus.wr_x        = 10'(wx);
    bus.wr_y        = 10'(wy);
    bus.wr_dir      = 2'(wd);
    bus.wr_active   = wa;
    bus.DrawX       = 10'(px);
    bus.DrawY       = 10'(py);
    bus.blank       = bl;
    eval(px, py, bl, h, id, ad, nh);
    @(posedge clk);
    if (fs) begin
      m_ovl  = m_flag;
      m_flag = 1'b0;
      for (int i = 0; i < NB; i++) lv[i] = sh[i];
    end else if (nh >= 2) begin
      m_flag = 1'b1;
    end
    if (we && wi < NB) sh[wi] = '{wx, wy, wd, wa};
    #1;
    chk("rom_addr", int'(bus.rom_addr), ad);
    chk("bullet_on", int'(bus.bullet_on), p_hit ? int'(rom_bits[p_addr]) : 0);
    if (p_hit) chk("bullet_idx", int'(bus.bullet_idx), p_idx);
`ifdef BULLET_OVERLAP_DETECT_EN
    chk("overlap_frame", int'(bus.overlap_frame), int'(m_ovl));
`else
    chk("overlap_frame", int'(bus.overlap_frame), 0);
`endif
    p_hit  = h;
    p_idx  = id;
    p_addr = ad;
  endtask

  task automatic pix(input int px, input int py, input bit bl);
    tick(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, px, py, bl);
  endtask

  task automatic wr(input int i, input int x, input int y, input int d, input bit a);
    tick(1'b0, 1'b1, i, x, y, d, a, 0, 0, 1'b0);
  endtask

  task automatic fstart();
    tick(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  typedef struct {
    int x;
    int y;
    int dir;
    int px;
    int py;
    bit bl;
    bit ehit;
    int eaddr;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{100, 50, 1, 103, 52, 1'b1, 1'b1, 19};
    vt[1]  = '{100, 50, 3, 101, 50, 1'b1, 1'b1, 48};
    vt[2]  = '{100, 50, 0, 100, 50, 1'b1, 1'b1, 56};
    vt[3]  = '{100, 50, 2, 102, 55, 1'b1, 1'b1, 21};
    vt[4]  = '{100, 50, 1, 108, 50, 1'b1, 1'b0, 0};
    vt[5]  = '{100, 50, 1,  99, 50, 1'b1, 1'b0, 0};
    vt[6]  = '{100, 50, 1, 107, 57, 1'b1, 1'b1, 63};
    vt[7]  = '{636, 10, 1, 639, 10, 1'b1, 1'b1, 3};
    vt[8]  = '{636, 10, 1,   0, 11, 1'b1, 1'b0, 0};
    vt[9]  = '{100, 50, 1, 103, 52, 1'b0, 1'b0, 0};
    vt[10] = '{  0,  0, 0,   7,  7, 1'b1, 1'b1, 7};

    rom_bits = {$urandom, $urandom};
    rom_bits[19] = 1'b1;
    rom_bits[48] = 1'b1;
    rom_bits[18] = 1'b1;
    model_reset();
    bus.frame_start = 1'b0; bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_x = '0;
    bus.wr_y = '0; bus.wr_dir = '0; bus.wr_active = 1'b0;
    bus.DrawX = '0; bus.DrawY = '0; bus.blank = 1'b0;

    #12;
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    chk("rst_bullet_on", int'(bus.bullet_on), 0);
    chk("rst_bullet_idx", int'(bus.bullet_idx), 0);
    chk("rst_overlap", int'(bus.overlap_frame), 0);
    #10 rst_n = 1'b1;

    // Empty tables: nothing anywhere on screen.
    for (int k = 0; k < 40; k++) pix($urandom_range(639), $urandom_range(479), 1'b1);

    foreach (vt[k]) begin
      wr(0, vt[k].x, vt[k].y, vt[k].dir, 1'b1);
      fstart();
      pix(vt[k].px, vt[k].py, vt[k].bl);
      chk("tbl_addr", int'(bus.rom_addr), vt[k].eaddr);
      pix(0, 0, 1'b0);
      chk("tbl_on", int'(bus.bullet_on), vt[k].ehit ? int'(rom_bits[vt[k].eaddr]) : 0);
      if (vt[k].ehit) chk("tbl_idx", int'(bus.bullet_idx), 0);
    end

    // Overlapping slots 1 and 2: lower index wins, overlap reported one frame later.
    wr(0, 100, 50, 1, 1'b0);
    wr(1, 195, 195, 1, 1'b1);
    wr(2, 198, 199, 2, 1'b1);
    fstart();
    pix(200, 200, 1'b1);
    pix(0, 0, 1'b0);
    chk("prio_idx", int'(bus.bullet_idx), 1);
    fstart();
`ifdef BULLET_OVERLAP_DETECT_EN
    chk("ovl_set", int'(bus.overlap_frame), 1);
`else
    chk("ovl_set", int'(bus.overlap_frame), 0);
`endif
    pix(196, 196, 1'b1);
    pix(50, 50, 1'b1);
    fstart();
    chk("ovl_clear", int'(bus.overlap_frame), 0);

    // Slot 3 written alongside frame_start only shows up a frame later.
    tick(1'b1, 1'b1, 3, 300, 300, 1, 1'b1, 0, 0, 1'b0);
    pix(302, 302, 1'b1);
    chk("s3_late_addr", int'(bus.rom_addr), 0);
    fstart();
    pix(302, 302, 1'b1);
    chk("s3_addr", int'(bus.rom_addr), 18);
    pix(0, 0, 1'b0);
    chk("s3_idx", int'(bus.bullet_idx), 3);
    chk("s3_on", int'(bus.bullet_on), 1);

    for (int k = 0; k < 2500; k++) begin
      int op;
      op = int'($urandom_range(99));
      if (op < 6) begin
        wr($urandom_range(NB - 1),
           ($urandom_range(9) == 0) ? 630 + $urandom_range(9) : $urandom_range(80),
           $urandom_range(80), $urandom_range(3), $urandom_range(4) != 0);
      end else if (op < 8) begin
        fstart();
      end else begin
        pix(($urandom_range(19) == 0) ? $urandom_range(639) : $urandom_range(90),
            $urandom_range(90), $urandom_range(9) != 0);
      end
    end

    // Asynchronous reset in the middle of a line.
    wr(0, 10, 10, 1, 1'b1);
    fstart();
    pix(12, 12, 1'b1);
    pix(13, 12, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_rom_addr", int'(bus.rom_addr), 0);
    chk("arst_bullet_on", int'(bus.bullet_on), 0);
    chk("arst_bullet_idx", int'(bus.bullet_idx), 0);
    chk("arst_overlap", int'(bus.overlap_frame), 0);
    model_reset();
    #2 rst_n = 1'b1;
    pix(12, 12, 1'b1);
    fstart();
    pix(12, 12, 1'b1);
    chk("arst_empty", int'(bus.rom_addr), 0);
    wr(0, 10, 10, 1, 1'b1);
    fstart();
    pix(12, 12, 1'b1);
    chk("arst_redraw", int'(bus.rom_addr), 18);
    pix(0, 0, 1'b0);
    chk("arst_redraw_on", int'(bus.bullet_on), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
